// File: rtl/vip_bch_types_pkg.sv
// Shared types for the BCH LFSR encoder.
//   MAX_PARITY_DEFAULT : default maximum parity length r (bits)
//   LEN_WIDTH_DEFAULT  : default width of the message-length field
//   bch_state_e        : encoder FSM states (idle, message, parity)
//   bch_cfg_t          : per-codeword configuration (k, r, gen) captured at codeword start
// The struct is sized from the defaults, so the top-level parameters must not exceed them.
package vip_bch_types_pkg;

    localparam int unsigned MAX_PARITY_DEFAULT = 64;
    localparam int unsigned LEN_WIDTH_DEFAULT  = 16;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StMsg  = 2'd1,
        StPar  = 2'd2
    } bch_state_e;

    typedef struct packed {
        logic [LEN_WIDTH_DEFAULT-1:0]  k;
        logic [7:0]                    r;
        logic [MAX_PARITY_DEFAULT-1:0] gen;
    } bch_cfg_t;

endpackage

// File: rtl/bch_lfsr_div.sv
// Polynomial-division LFSR of the systematic BCH encoder.
//   clk, rst_n : clock, asynchronous active-low reset (clears the register)
//   clr        : start from an all-zero register (combined with shift for the first bit)
//   shift      : advance one step; fb = din ^ lfsr[r-1], lfsr = (lfsr << 1) ^ (fb ? gen : 0)
//   din        : input bit (message bit, or lfsr[r-1] to get a plain zero-fill shift)
//   gen        : generator coefficients g0..g(r-1), g(r)=1 implied
//   r          : active register length; bits at r and above are kept zero
//   lfsr       : current register contents
module bch_lfsr_div #(
    parameter int unsigned WIDTH_P = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               shift,
    input  logic               din,
    input  logic [WIDTH_P-1:0] gen,
    input  logic [7:0]         r,
    output logic [WIDTH_P-1:0] lfsr
);

    localparam int unsigned IdxW = (WIDTH_P > 1) ? $clog2(WIDTH_P) : 1;

    logic [WIDTH_P-1:0] lfsr_q, lfsr_d, base, mask;
    logic [IdxW-1:0]    msb_idx;
    logic               fb;

    assign msb_idx = IdxW'(r - 8'd1);
    // Shifting by r >= WIDTH_P yields zero, so the mask saturates to all ones.
    assign mask    = ~({WIDTH_P{1'b1}} << r);

    always_comb begin
        base   = clr ? '0 : lfsr_q;
        fb     = din ^ base[msb_idx];
        lfsr_d = lfsr_q;
        if (shift) begin
            lfsr_d = ((base << 1) ^ (fb ? gen : '0)) & mask;
        end else if (clr) begin
            lfsr_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= '0;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr = lfsr_q;

endmodule

// File: rtl/bch_lfsr_encoder.sv
// Systematic bit-serial BCH encoder: k message bits pass through unchanged, followed by the
// r parity bits of m(x)*x^r mod g(x), MSB first, with out_last on the final parity bit.
//   clk, rst_n           : clock, asynchronous active-low reset
//   cfg_k, cfg_r, cfg_gen: message length, parity length, generator g0..g(r-1)
//   cfg_err              : current configuration is illegal (blocks codeword start)
//   in_valid/in_ready/in_data             : message bit stream, MSB first
//   out_valid/out_ready/out_data/out_last : codeword bit stream
//   busy                 : FSM not idle
//   cw_count             : completed-codeword counter, only with BCH_ENC_STATS_EN defined
module bch_lfsr_encoder
    import vip_bch_types_pkg::*;
#(
    parameter int unsigned MAX_PARITY_P = MAX_PARITY_DEFAULT,
    parameter int unsigned LEN_WIDTH_P  = LEN_WIDTH_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [LEN_WIDTH_P-1:0]  cfg_k,
    input  logic [7:0]              cfg_r,
    input  logic [MAX_PARITY_P-1:0] cfg_gen,
    output logic                    cfg_err,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_data,
    output logic                    out_last,
`ifdef BCH_ENC_STATS_EN
    output logic [31:0]             cw_count,
`endif
    output logic                    busy
);

    localparam int unsigned IdxW = (MAX_PARITY_P > 1) ? $clog2(MAX_PARITY_P) : 1;

    bch_state_e state_q, state_d;
    bch_cfg_t   cfg_q, cfg_d;

    logic [LEN_WIDTH_P-1:0]  cnt_q, cnt_d, cnt_inc;
    logic                    out_valid_q, out_valid_d;
    logic                    out_data_q, out_data_d;
    logic                    out_last_q, out_last_d;
    logic                    out_free, in_ready_c, in_acc;
    logic                    last_msg, last_par, k_is_one, par_bit;
    logic                    lfsr_clr, lfsr_shift, lfsr_din;
    logic [MAX_PARITY_P-1:0] lfsr, lfsr_gen;
    logic [7:0]              lfsr_r;
    logic [IdxW-1:0]         msb_idx;
    logic [LEN_WIDTH_P+8:0]  len_sum;

    // Illegal configuration: empty message/parity, parity too long, or n overflows the field.
    assign len_sum = {9'b0, cfg_k} + {{(LEN_WIDTH_P + 1){1'b0}}, cfg_r};
    assign cfg_err = (cfg_k == '0) || (cfg_r == 8'd0) || (32'(cfg_r) > MAX_PARITY_P) ||
                     (|len_sum[LEN_WIDTH_P+8:LEN_WIDTH_P]);

    assign out_free = !out_valid_q || out_ready;
    assign in_acc   = in_valid && in_ready;
    assign cnt_inc  = cnt_q + 1'b1;
    assign k_is_one = (cfg_k == LEN_WIDTH_P'(1));
    assign last_msg = (cnt_inc == cfg_q.k);
    assign last_par = (cnt_inc == LEN_WIDTH_P'(cfg_q.r));
    assign msb_idx  = IdxW'(cfg_q.r - 8'd1);
    assign par_bit  = lfsr[msb_idx];

    // The first message bit is divided before cfg is latched, so it uses the live inputs.
    assign lfsr_gen = (state_q == StIdle) ? cfg_gen : cfg_q.gen;
    assign lfsr_r   = (state_q == StIdle) ? cfg_r : cfg_q.r;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (in_acc) state_d = k_is_one ? StPar : StMsg;
            StMsg:   if (in_acc && last_msg) state_d = StPar;
            StPar:   if (out_free && last_par) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs and datapath next-state.
    always_comb begin
        in_ready_c  = 1'b0;
        cnt_d       = cnt_q;
        cfg_d       = cfg_q;
        out_valid_d = out_valid_q && !out_ready;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q && !out_ready;
        lfsr_clr    = 1'b0;
        lfsr_shift  = 1'b0;
        lfsr_din    = in_data;
        unique case (state_q)
            StIdle: begin
                in_ready_c = out_free && !cfg_err;
                if (in_acc) begin
                    cfg_d       = '{k: cfg_k, r: cfg_r, gen: cfg_gen};
                    cnt_d       = k_is_one ? '0 : LEN_WIDTH_P'(1);
                    lfsr_clr    = 1'b1;
                    lfsr_shift  = 1'b1;
                    out_valid_d = 1'b1;
                    out_data_d  = in_data;
                    out_last_d  = 1'b0;
                end
            end
            StMsg: begin
                in_ready_c = out_free;
                if (in_acc) begin
                    cnt_d       = last_msg ? '0 : cnt_inc;
                    lfsr_shift  = 1'b1;
                    out_valid_d = 1'b1;
                    out_data_d  = in_data;
                    out_last_d  = 1'b0;
                end
            end
            StPar: begin
                if (out_free) begin
                    cnt_d       = last_par ? '0 : cnt_inc;
                    lfsr_shift  = 1'b1;
                    // Feeding the MSB back cancels the feedback term: plain zero-fill shift.
                    lfsr_din    = par_bit;
                    out_valid_d = 1'b1;
                    out_data_d  = par_bit;
                    out_last_d  = last_par;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            cfg_q       <= cfg_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
        end
    end

    bch_lfsr_div #(
        .WIDTH_P(MAX_PARITY_P)
    ) u_lfsr_div (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (lfsr_clr),
        .shift(lfsr_shift),
        .din  (lfsr_din),
        .gen  (lfsr_gen),
        .r    (lfsr_r),
        .lfsr (lfsr)
    );

`ifdef BCH_ENC_STATS_EN
    logic [31:0] cw_count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cw_count_q <= '0;
        end else if (out_valid_q && out_last_q && out_ready) begin
            cw_count_q <= cw_count_q + 32'd1;
        end
    end

    assign cw_count = cw_count_q;
`endif

    // in_ready is forced low while reset is asserted.
    assign in_ready  = rst_n && in_ready_c;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_bch_lfsr_encoder.sv
module tb_bch_lfsr_encoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] cfg_k = 16'd4;
    logic [7:0]  cfg_r = 8'd3;
    logic [63:0] cfg_gen = 64'h3;
    logic        cfg_err;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_data = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        out_data;
    logic        out_last;
    logic        busy;
`ifdef BCH_ENC_STATS_EN
    logic [31:0] cw_count;
`endif

    int          n_checks = 0;
    int          n_fail = 0;
    logic [1:0]  exp_q[$];   // {data, last}
    bit          rx_q[$];
    bit          rand_ready = 1'b0;

    always #5 clk = ~clk;

    bch_lfsr_encoder dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cfg_k    (cfg_k),
        .cfg_r    (cfg_r),
        .cfg_gen  (cfg_gen),
        .cfg_err  (cfg_err),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_last (out_last),
`ifdef BCH_ENC_STATS_EN
        .cw_count (cw_count),
`endif
        .busy     (busy)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: long division of m(x)*x^r by g(x) on a bit list, highest degree first.
    function automatic bit [63:0] ref_parity(input bit [255:0] msg, input int k, input int r,
                                             input bit [63:0] gen);
        bit        work[$];
        bit [63:0] rem = '0;
        for (int i = 0; i < k; i++) work.push_back(msg[k-1-i]);
        for (int j = 0; j < r; j++) work.push_back(1'b0);
        for (int i = 0; i < k; i++) begin
            if (work[i]) begin
                work[i] = 1'b0;
                for (int j = 1; j <= r; j++) work[i+j] = work[i+j] ^ gen[r-j];
            end
        end
        for (int j = 0; j < r; j++) rem[r-1-j] = work[k+j];
        return rem;
    endfunction

    function automatic logic [63:0] rx_value();
        logic [63:0] v = '0;
        foreach (rx_q[i]) v = {v[62:0], rx_q[i]};
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Output compare: every handshake against the expected queue, plus stall stability.
    initial begin : compare
        logic       prev_stall = 1'b0;
        logic       prev_d = 1'b0;
        logic       prev_l = 1'b0;
        logic [1:0] e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
                continue;
            end
            if (prev_stall) begin
                chk("stall_valid_held", out_valid, 1);
                chk("stall_data_held", out_data, prev_d);
                chk("stall_last_held", out_last, prev_l);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output: got data=%0b last=%0b, expected no transfer",
                             out_data, out_last);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_data", out_data, e[1]);
                    chk("out_last", out_last, e[0]);
                    rx_q.push_back(out_data);
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_d     = out_data;
            prev_l     = out_last;
        end
    end

    initial begin : ready_drv
        forever begin
            @(posedge clk);
            #1;
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_msg(input bit [255:0] msg, input int k, input int r, input bit [63:0] gen,
                            input int max_bits, input bit scramble, input int stall_pct);
        bit [63:0] par;
        bit        acc;
        int        waitc;
        cfg_k   = 16'(k);
        cfg_r   = 8'(r);
        cfg_gen = gen;
        par     = ref_parity(msg, k, r, gen);
        for (int i = 0; i < k && i < max_bits; i++) exp_q.push_back({msg[k-1-i], 1'b0});
        if (max_bits >= k) begin
            for (int j = 0; j < r; j++) exp_q.push_back({par[r-1-j], j == r - 1});
        end
        for (int i = 0; i < k && i < max_bits; i++) begin
            if (stall_pct > 0 && $urandom_range(0, 99) < stall_pct) begin
                in_valid = 1'b0;
                tick();
            end
            in_valid = 1'b1;
            in_data  = msg[k-1-i];
            waitc    = 0;
            do begin
                @(negedge clk);
                acc = in_ready;
                @(posedge clk);
                #1;
                waitc++;
            end while (!acc && waitc < 300);
            if (!acc) begin
                n_checks++;
                n_fail++;
                $display("FAIL input_accept_timeout: bit %0d not accepted, expected acceptance", i);
                in_valid = 1'b0;
                return;
            end
            if (i == 0 && scramble) begin
                cfg_k   = 16'($urandom);
                cfg_r   = 8'($urandom);
                cfg_gen = {$urandom, $urandom};
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int c = 0;
        while ((exp_q.size() != 0 || busy || out_valid) && c < 2000) begin
            tick();
            c++;
        end
        chk({name, "_pending_bits"}, 64'(exp_q.size()), 0);
        chk({name, "_busy_after"}, busy, 0);
    endtask

    task automatic check_reset_outputs(input string name);
        chk({name, "_out_valid"}, out_valid, 0);
        chk({name, "_out_data"}, out_data, 0);
        chk({name, "_out_last"}, out_last, 0);
        chk({name, "_busy"}, busy, 0);
        chk({name, "_in_ready"}, in_ready, 0);
    endtask

    task automatic release_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
    endtask

    initial begin : main
        bit [255:0] m;
        int         ks[7] = '{4, 0, 4, 65530, 65529, 4, 1};
        int         rs[7] = '{0, 3, 65, 6, 6, 64, 1};
        bit         err_exp;
        int         bubbles;

        // Reset values.
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("reset");
`ifdef BCH_ENC_STATS_EN
        chk("reset_cw_count", cw_count, 0);
`endif
        release_reset();

        // Pin the reference model with hand-computed remainders.
        chk("model_hamming_1000", ref_parity(256'b1000, 4, 3, 64'h3), 64'b101);
        chk("model_bch_ones", ref_parity(256'h7F, 7, 8, 64'hD1), 64'hFF);
        chk("model_bch_zeros", ref_parity(256'h0, 7, 8, 64'hD1), 64'h0);

        // Hamming(7,4), message 1000.
        rx_q.delete();
        send_msg(256'b1000, 4, 3, 64'h3, 99, 1'b0, 0);
        chk("busy_in_parity", busy, 1);
        wait_drain("hamming");
        chk("hamming_codeword", rx_value(), 64'b1000101);
        chk("hamming_length", 64'(rx_q.size()), 7);

        // BCH(15,7) all ones and all zeros.
        rx_q.delete();
        send_msg(256'h7F, 7, 8, 64'hD1, 99, 1'b0, 0);
        wait_drain("bch_ones");
        chk("bch_ones_codeword", rx_value(), 64'h7FFF);
        rx_q.delete();
        send_msg(256'h0, 7, 8, 64'hD1, 99, 1'b0, 0);
        wait_drain("bch_zeros");
        chk("bch_zeros_codeword", rx_value(), 64'h0);
        chk("bch_zeros_length", 64'(rx_q.size()), 15);

        // Configuration legality in IDLE.
        for (int i = 0; i < 7; i++) begin
            cfg_k   = 16'(ks[i]);
            cfg_r   = 8'(rs[i]);
            err_exp = (ks[i] == 0) || (rs[i] == 0) || (rs[i] > 64) || (ks[i] + rs[i] >= 65536);
            in_valid = err_exp;
            #1;
            chk($sformatf("cfg_err_k%0d_r%0d", ks[i], rs[i]), cfg_err, err_exp);
            chk($sformatf("in_ready_k%0d_r%0d", ks[i], rs[i]), in_ready, !err_exp);
            if (err_exp) begin
                tick();
                chk($sformatf("no_start_k%0d_r%0d", ks[i], rs[i]), busy | out_valid, 0);
            end
            in_valid = 1'b0;
        end
        rx_q.delete();
        send_msg(256'b0101, 4, 3, 64'h3, 99, 1'b0, 0);
        wait_drain("legal_after_err");
        chk("legal_after_err_codeword", rx_value(),
            {57'b0, 4'b0101, 3'(ref_parity(256'b0101, 4, 3, 64'h3))});

        // Random BCH(15,7) messages with 50% output backpressure and changing cfg inputs.
        rand_ready = 1'b1;
        for (int n = 0; n < 100; n++) begin
            m = 256'($urandom_range(0, 127));
            send_msg(m, 7, 8, 64'hD1, 99, 1'b1, 20);
        end
        wait_drain("random");
        rand_ready = 1'b0;
        tick();

        // Reset after 3 of 7 message bits.
        send_msg(256'h5B, 7, 8, 64'hD1, 3, 1'b0, 0);
        #2 rst_n = 1'b0;
        exp_q.delete();
        #1 check_reset_outputs("midreset");
        release_reset();
        rx_q.delete();
        send_msg(256'h35, 7, 8, 64'hD1, 99, 1'b0, 0);
        wait_drain("after_midreset");
        chk("after_midreset_codeword", rx_value(),
            {49'b0, 7'h35, 8'(ref_parity(256'h35, 7, 8, 64'hD1))});

        // Five back-to-back Hamming codewords with out_ready held high.
        rst_n = 1'b0;
        exp_q.delete();
        release_reset();
        bubbles = 0;
        fork
            begin
                for (int n = 0; n < 5; n++) begin
                    send_msg(256'($urandom_range(0, 15)), 4, 3, 64'h3, 99, 1'b0, 0);
                end
            end
            begin
                int c = 0;
                @(negedge clk);
                while (!out_valid && c < 50) begin
                    @(negedge clk);
                    c++;
                end
                for (int i = 0; i < 35; i++) begin
                    if (i > 0) @(negedge clk);
                    if (!out_valid) bubbles++;
                end
            end
        join
        chk("b2b_bubbles", 64'(bubbles), 0);
        wait_drain("b2b");
`ifdef BCH_ENC_STATS_EN
        chk("b2b_cw_count", cw_count, 5);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
